// File: rtl/mem_req_unit_if.sv
// mem_req_unit_if: SRAM-like data bus between the memory request unit and the
// data memory.
//   master modport : request unit (drives req/wr/size/wstrb/addr/wdata)
//   slave modport  : memory (drives addr_ok/data_ok/rdata)
interface mem_req_unit_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/mem_req_unit.sv
// mem_req_unit: request side of the data SRAM bus. Converts EXE load/store ops
// into bus requests, tracks outstanding transactions in a tag FIFO, aligns
// returned read data into load results and cancels in-flight responses on flush.
//
// Ports:
//   clk, reset (sync, active-low)
//   es_req_valid/es_req_ready/es_mem_op/es_addr/es_wdata/es_ale : EXE side
//   flush                                   : exception/ertn flush
//   bus (mem_req_unit_if.master)            : data SRAM bus
//   ms_resp_valid/ms_resp_data/ms_resp_ready: load results to MEM
//   busy                                    : tags in flight or responses buffered
//
// Build option MEM_REQ_ALE_CHECK_EN: when defined, misaligned half/word ops
// raise es_ale and complete without a bus request. When undefined, es_ale is
// tied 0 and misaligned half/word ops issue with the low address bits forced
// to 00.
//
// state | meaning
// IDLE  | no request on the bus; may accept a new op
// REQ   | request on the bus, waiting for addr_ok
module mem_req_unit #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es_req_valid,
  output logic                 es_req_ready,
  input  logic [7:0]           es_mem_op,
  input  logic [31:0]          es_addr,
  input  logic [31:0]          es_wdata,
  output logic                 es_ale,
  input  logic                 flush,
  mem_req_unit_if.master       bus,
  output logic                 ms_resp_valid,
  output logic [31:0]          ms_resp_data,
  input  logic                 ms_resp_ready,
  output logic                 busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  localparam int             PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0]  LAST  = PW'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]     MAX_C = 3'(MAX_OUTSTANDING);

  logic [0:0]  state_q, state_d;
  logic        flushed_q, flushed_d;
  logic        req_q, req_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  ldop_q;

  logic [4:0]  tag_op_q  [MAX_OUTSTANDING];
  logic [1:0]  tag_off_q [MAX_OUTSTANDING];
  logic        tag_st_q  [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] tag_cancel_q, tag_cancel_d;
  logic [PW-1:0] tag_wp_q, tag_rp_q;
  logic [2:0]  tag_cnt_q, tag_cnt_d;

  logic [31:0] resp_data_q [MAX_OUTSTANDING];
  logic [PW-1:0] resp_wp_q, resp_rp_q;
  logic [2:0]  resp_cnt_q, resp_cnt_d;

  logic        is_store, is_half, is_word, misal, ale, idle;
  logic        ale_fire, issue, addr_hs, tag_push, tag_pop, resp_push, resp_pop;
  logic [1:0]  off_eff, size_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, head_result;
  logic [2:0]  cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // op bits: [4] ld_b, [3] ld_bu, [2] ld_h, [1] ld_hu, [0] ld_w
  function automatic logic [31:0] extract(input logic [4:0] op, input logic [1:0] off,
                                          input logic st, input logic [31:0] d);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = d >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? d[31:16] : d[15:0];
    if (st)         return 32'h0;
    else if (op[4]) return {{24{b[7]}}, b};
    else if (op[3]) return {24'h0, b};
    else if (op[2]) return {{16{h[15]}}, h};
    else if (op[1]) return {16'h0, h};
    else if (op[0]) return d;
    else            return 32'h0;
  endfunction

  always_comb begin
    is_store = |es_mem_op[7:5];
    is_half  = es_mem_op[6] | es_mem_op[2] | es_mem_op[1];
    is_word  = es_mem_op[5] | es_mem_op[0];
    misal    = (is_half & es_addr[0]) | (is_word & (es_addr[1:0] != 2'b00));
  end

`ifdef MEM_REQ_ALE_CHECK_EN
  assign ale     = misal;
  assign off_eff = es_addr[1:0];
`else
  assign ale     = 1'b0;
  assign off_eff = misal ? 2'b00 : es_addr[1:0];
`endif

  assign cnt      = tag_cnt_q + resp_cnt_q;
  assign idle     = (state_q == S_IDLE);
  assign ale_fire = idle & es_req_valid & ale;
  assign issue    = idle & es_req_valid & ~ale & ~flush & (cnt < MAX_C);
  assign addr_hs  = ~idle & bus.data_sram_addr_ok;

  // A flush seen at any point of REQ (including the addr_ok cycle) means the
  // EXE op was squashed: no ready pulse, and its tag is born cancelled.
  assign es_req_ready = ale_fire | (addr_hs & ~(flushed_q | flush));
  assign es_ale       = ale_fire;

  always_comb begin
    size_d  = is_word ? 2'd2 : (is_half ? 2'd1 : 2'd0);
    wstrb_d = 4'b0000;
    if (is_store) begin
      if (is_word)      wstrb_d = 4'b1111;
      else if (is_half) wstrb_d = off_eff[1] ? 4'b1100 : 4'b0011;
      else              wstrb_d = 4'b0001 << off_eff;
    end
    if (is_word)      wdata_d = es_wdata;
    else if (is_half) wdata_d = {2{es_wdata[15:0]}};
    else              wdata_d = {4{es_wdata[7:0]}};
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    flushed_d = flushed_q;
    if (issue) begin
      state_d   = S_REQ;
      req_d     = 1'b1;
      flushed_d = 1'b0;
    end else if (!idle) begin
      flushed_d = flushed_q | flush;
      if (addr_hs) begin
        state_d   = S_IDLE;
        req_d     = 1'b0;
        flushed_d = 1'b0;
      end
    end
  end

  assign tag_push    = addr_hs;
  assign tag_pop     = bus.data_sram_data_ok & (tag_cnt_q != 3'd0);
  assign head_result = extract(tag_op_q[tag_rp_q], tag_off_q[tag_rp_q],
                               tag_st_q[tag_rp_q], bus.data_sram_rdata);
  assign resp_push   = tag_pop & ~tag_cancel_q[tag_rp_q] & ~flush;
  assign resp_pop    = ms_resp_valid & ms_resp_ready & ~flush;

  always_comb begin
    tag_cancel_d = tag_cancel_q;
    if (tag_push) tag_cancel_d[tag_wp_q] = flushed_q;
    if (flush)    tag_cancel_d = '1;
    tag_cnt_d  = tag_cnt_q + {2'b00, tag_push} - {2'b00, tag_pop};
    resp_cnt_d = flush ? 3'd0 : resp_cnt_q + {2'b00, resp_push} - {2'b00, resp_pop};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      flushed_q    <= 1'b0;
      req_q        <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      wstrb_q      <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      ldop_q       <= 5'd0;
      tag_cancel_q <= '0;
      tag_wp_q     <= '0;
      tag_rp_q     <= '0;
      tag_cnt_q    <= 3'd0;
      resp_wp_q    <= '0;
      resp_rp_q    <= '0;
      resp_cnt_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      flushed_q    <= flushed_d;
      req_q        <= req_d;
      tag_cancel_q <= tag_cancel_d;
      tag_cnt_q    <= tag_cnt_d;
      resp_cnt_q   <= resp_cnt_d;
      if (issue) begin
        wr_q    <= is_store;
        size_q  <= size_d;
        wstrb_q <= wstrb_d;
        addr_q  <= {es_addr[31:2], off_eff};
        wdata_q <= wdata_d;
        ldop_q  <= es_mem_op[4:0];
      end
      if (tag_push) tag_wp_q <= ptr_inc(tag_wp_q);
      if (tag_pop)  tag_rp_q <= ptr_inc(tag_rp_q);
      if (flush) begin
        resp_wp_q <= '0;
        resp_rp_q <= '0;
      end else begin
        if (resp_push) resp_wp_q <= ptr_inc(resp_wp_q);
        if (resp_pop)  resp_rp_q <= ptr_inc(resp_rp_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_op_q[tag_wp_q]  <= ldop_q;
      tag_off_q[tag_wp_q] <= addr_q[1:0];
      tag_st_q[tag_wp_q]  <= wr_q;
    end
    if (resp_push) resp_data_q[resp_wp_q] <= head_result;
  end

  assign bus.data_sram_req   = req_q;
  assign bus.data_sram_wr    = wr_q;
  assign bus.data_sram_size  = size_q;
  assign bus.data_sram_wstrb = wstrb_q;
  assign bus.data_sram_addr  = addr_q;
  assign bus.data_sram_wdata = wdata_q;

  assign ms_resp_valid = (resp_cnt_q != 3'd0);
  assign ms_resp_data  = resp_data_q[resp_rp_q];
  assign busy          = (cnt != 3'd0);

endmodule
